// File: rtl/toaplan2_cen_sched_if.sv
// Register/enable bundle for the Toaplan2 clock-enable scheduler.
//   WR     host -> sched  one-cycle register write strobe
//   ADDR   host -> sched  [2:1] channel, [0] 0 = numerator N, 1 = denominator M
//   DIN    host -> sched  write data; N takes [7:0], M takes [15:0]
//   PAUSE  host -> sched  freezes every channel while high
//   CEN    sched -> host  per-channel enable pulse, one cycle wide
//   CENB   sched -> host  per-channel mid-period pulse
//   PEND   sched -> host  per-channel shadow-update-pending flag
interface toaplan2_cen_sched_if;
  logic        WR;
  logic [2:0]  ADDR;
  logic [15:0] DIN;
  logic        PAUSE;
  logic [3:0]  CEN;
  logic [3:0]  CENB;
  logic [3:0]  PEND;

  modport master (
    output WR, ADDR, DIN, PAUSE,
    input  CEN, CENB, PEND
  );

  modport slave (
    input  WR, ADDR, DIN, PAUSE,
    output CEN, CENB, PEND
  );
endinterface

// File: rtl/toaplan2_cen_sched.sv
// Runtime-programmable fractional clock-enable scheduler. Four independent channels each
// emit n pulses every m cycles of CLK96 (spacing floor/ceil of m/n) on CEN, plus a
// mid-period pulse on CENB. Rates are written into shadow registers and copied into the
// active set only on a period boundary, so reprogramming never shortens or splits a period.
// PAUSE holds every accumulator so counting resumes without phase loss.
//   CLK96      system clock (96 MHz), the only clock
//   RESET96_N  asynchronous active-low reset
//   bus        register port in, CEN/CENB/PEND out (all outputs registered)
module toaplan2_cen_sched #(
  parameter int unsigned N0 = 1,
  parameter int unsigned M0 = 24,
  parameter int unsigned N1 = 1,
  parameter int unsigned M1 = 48,
  parameter int unsigned N2 = 9,
  parameter int unsigned M2 = 128,
  parameter int unsigned N3 = 1,
  parameter int unsigned M3 = 96
) (
  input logic                 CLK96,
  input logic                 RESET96_N,
  toaplan2_cen_sched_if.slave bus
);

  localparam int unsigned NumCh = 4;
  localparam int unsigned NRst [NumCh] = '{N0, N1, N2, N3};
  localparam int unsigned MRst [NumCh] = '{M0, M1, M2, M3};

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    localparam logic [7:0]  NInit = 8'(NRst[g]);
    localparam logic [15:0] MInit = 16'(MRst[g]);
    localparam logic [1:0]  ChId  = 2'(g);

    logic [7:0]  n_q, n_d, sn_q, sn_d;
    logic [15:0] m_q, m_d, sm_q, sm_d;
    logic [16:0] acc_q, acc_d;
    logic        cen_q, cen_d, cenb_q, cenb_d, pend_q, pend_d;

    logic [16:0] sum, m_ext, half_ext, residue;
    logic        stopped, shadow_stopped, wr_hit, apply;

    // acc < m <= 65535 and n <= 255, so the 17-bit sum cannot wrap.
    assign sum      = acc_q + {9'd0, n_q};
    assign m_ext    = {1'b0, m_q};
    assign half_ext = {2'b00, m_q[15:1]};
    assign residue  = sum - m_ext;

    assign stopped        = (n_q == 8'd0) || (m_q == 16'd0) || ({8'd0, n_q} > m_q);
    assign shadow_stopped = (sn_q == 8'd0) || (sm_q == 16'd0) || ({8'd0, sn_q} > sm_q);
    assign wr_hit         = bus.WR && (bus.ADDR[2:1] == ChId);

    always_comb begin
      n_d    = n_q;
      m_d    = m_q;
      sn_d   = sn_q;
      sm_d   = sm_q;
      acc_d  = acc_q;
      pend_d = pend_q;
      cen_d  = 1'b0;
      cenb_d = 1'b0;
      apply  = 1'b0;

      if (!bus.PAUSE) begin
        if (stopped) begin
          // A stopped channel has no boundary to wait for, so a pending rate starts it.
          acc_d = '0;
          apply = pend_q;
        end else begin
          cenb_d = (acc_q < half_ext) && (sum >= half_ext) && (sum < m_ext);
          if (sum >= m_ext) begin
            cen_d = 1'b1;
            acc_d = residue;
            apply = pend_q;
          end else begin
            acc_d = sum;
          end
        end
      end

      // Apply takes the pre-edge shadow; the residue from the old m carries over unless it
      // would already exceed the new period or the new rate stops the channel.
      if (apply) begin
        n_d    = sn_q;
        m_d    = sm_q;
        pend_d = 1'b0;
        if (shadow_stopped || (acc_d >= {1'b0, sm_q})) begin
          acc_d = '0;
        end
      end

      // A write on the apply edge lands after the copy, so it stays pending.
      if (wr_hit) begin
        if (bus.ADDR[0]) begin
          sm_d = bus.DIN;
        end else begin
          sn_d = bus.DIN[7:0];
        end
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
        n_q    <= NInit;
        m_q    <= MInit;
        sn_q   <= NInit;
        sm_q   <= MInit;
        acc_q  <= '0;
        cen_q  <= 1'b0;
        cenb_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        n_q    <= n_d;
        m_q    <= m_d;
        sn_q   <= sn_d;
        sm_q   <= sm_d;
        acc_q  <= acc_d;
        cen_q  <= cen_d;
        cenb_q <= cenb_d;
        pend_q <= pend_d;
      end
    end

    assign bus.CEN[g]  = cen_q;
    assign bus.CENB[g] = cenb_q;
    assign bus.PEND[g] = pend_q;
  end

endmodule

// File: tb/tb_toaplan2_cen_sched.sv
// Self-checking bench for toaplan2_cen_sched: default-rate table, rewrite scenario table,
// hand sequences for stop/start, pause, write-on-apply and async reset, then random traffic
// checked every cycle against an integer model of the channel rules.
module tb_toaplan2_cen_sched;

  logic CLK96     = 1'b0;
  logic RESET96_N = 1'b1;

  toaplan2_cen_sched_if bus ();

  toaplan2_cen_sched #(
    .N0(1), .M0(24), .N1(1), .M1(48), .N2(9), .M2(128), .N3(1), .M3(96)
  ) dut (
    .CLK96    (CLK96),
    .RESET96_N(RESET96_N),
    .bus      (bus)
  );

  always #5 CLK96 = ~CLK96;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model state: one entry per channel, plain integers.
  localparam int NDef [4] = '{1, 1, 9, 1};
  localparam int MDef [4] = '{24, 48, 128, 96};
  int mn [4], mm [4], msn [4], msm [4], macc [4];
  bit mcen [4], mcenb [4], mpend [4];

  typedef struct {
    int ch; int lo; int hi; int first;
  } dflt_t;

  typedef struct {
    int ch; int wr_edge;
    logic [2:0] a1; logic [15:0] d1;
    logic [2:0] a2; logic [15:0] d2;
    int exp1; int exp2;
  } scn_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mn[k] = NDef[k]; mm[k] = MDef[k]; msn[k] = NDef[k]; msm[k] = MDef[k];
      macc[k] = 0; mcen[k] = 0; mcenb[k] = 0; mpend[k] = 0;
    end
  endtask

  // One rising edge of the reference: pulses are due whenever the running phase
  // (acc + n) reaches a full period m.
  task automatic model_step();
    int  s, nacc;
    bit  stopped, apply, ncen, ncenb;
    for (int k = 0; k < 4; k++) begin
      stopped = (mn[k] == 0) || (mm[k] == 0) || (mn[k] > mm[k]);
      apply = 0; ncen = 0; ncenb = 0; nacc = macc[k];
      if (!bus.PAUSE) begin
        if (stopped) begin
          nacc = 0; apply = mpend[k];
        end else begin
          s = macc[k] + mn[k];
          ncenb = (macc[k] < mm[k] / 2) && (s >= mm[k] / 2) && (s < mm[k]);
          if (s >= mm[k]) begin
            ncen = 1; nacc = s - mm[k]; apply = mpend[k];
          end else begin
            nacc = s;
          end
        end
      end
      if (apply) begin
        mn[k] = msn[k]; mm[k] = msm[k]; mpend[k] = 0;
        if (mn[k] == 0 || mm[k] == 0 || mn[k] > mm[k] || nacc >= mm[k]) nacc = 0;
      end
      macc[k] = nacc; mcen[k] = ncen; mcenb[k] = ncenb;
      if (bus.WR && int'(bus.ADDR[2:1]) == k) begin
        if (bus.ADDR[0]) msm[k] = int'(bus.DIN);
        else msn[k] = int'(bus.DIN[7:0]);
        mpend[k] = 1;
      end
    end
  endtask

  function automatic logic [11:0] model_vec();
    logic [11:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      v[k] = mcen[k]; v[4 + k] = mcenb[k]; v[8 + k] = mpend[k];
    end
    return v;
  endfunction

  task automatic tick();
    logic [11:0] dv, mv;
    @(posedge CLK96);
    model_step();
    edge_n++;
    #1;
    dv = {bus.PEND, bus.CENB, bus.CEN};
    mv = model_vec();
    checks++;
    if (dv !== mv) begin
      errors++;
      $display("FAIL model edge %0d: got %03h want %03h", edge_n, dv, mv);
    end
  endtask

  task automatic do_reset();
    RESET96_N = 1'b0;
    bus.WR = 1'b0; bus.ADDR = '0; bus.DIN = '0; bus.PAUSE = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", int'({bus.PEND, bus.CENB, bus.CEN}), 0);
    @(negedge CLK96);
    RESET96_N = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic write_at(input int e, input logic [2:0] a, input logic [15:0] d);
    run_to(e - 1);
    bus.WR = 1'b1; bus.ADDR = a; bus.DIN = d;
    tick();
    bus.WR = 1'b0;
  endtask

  task automatic wait_cen(input int ch, input int budget, output int e);
    e = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.CEN[ch]) begin
        e = edge_n;
        break;
      end
    end
  endtask

  dflt_t dtab [4];
  scn_t  stab [5];

  initial begin
    int cnt [4], first [4];
    int last2, bad_sp2, cenb0, bad_cenb0, e, pcnt;

    dtab[0] = '{0, 40, 40, 24};
    dtab[1] = '{1, 20, 20, 48};
    dtab[2] = '{2, 67, 68, 15};
    dtab[3] = '{3, 10, 10, 96};

    stab[0] = '{0, 30, 3'b000, 16'd1, 3'b001, 16'd12, 48, 60};
    stab[1] = '{1, 10, 3'b010, 16'd2, 3'b011, 16'd96, 48, 96};
    stab[2] = '{2,  5, 3'b100, 16'd1, 3'b101, 16'd10, 15, 18};
    stab[3] = '{2,  5, 3'b100, 16'd1, 3'b101, 16'd5,  15, 20};
    stab[4] = '{3, 20, 3'b110, 16'd3, 3'b111, 16'd96, 96, 128};

    #2;
    // Default rates over 960 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin cnt[k] = 0; first[k] = -1; end
    last2 = 0; bad_sp2 = 0; cenb0 = 0; bad_cenb0 = 0;
    for (int i = 0; i < 960; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (bus.CEN[k]) begin
          if (cnt[k] == 0) first[k] = edge_n;
          cnt[k]++;
        end
      end
      if (bus.CEN[2]) begin
        if (cnt[2] > 1 && (edge_n - last2 < 14 || edge_n - last2 > 15)) bad_sp2++;
        last2 = edge_n;
      end
      if (bus.CENB[0]) begin
        cenb0++;
        if (edge_n % 24 != 12) bad_cenb0++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check_range($sformatf("dflt_count_ch%0d", dtab[i].ch), cnt[dtab[i].ch], dtab[i].lo,
                  dtab[i].hi);
      check($sformatf("dflt_first_ch%0d", dtab[i].ch), first[dtab[i].ch], dtab[i].first);
    end
    check("ch2_spacing_bad", bad_sp2, 0);
    check("cenb0_count", cenb0, 40);
    check("cenb0_phase_bad", bad_cenb0, 0);

    // Rate rewrites mid-period: old period finishes, new one starts on that boundary.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      write_at(stab[i].wr_edge, stab[i].a1, stab[i].d1);
      write_at(stab[i].wr_edge + 1, stab[i].a2, stab[i].d2);
      check($sformatf("scn%0d_pend_set", i), int'(bus.PEND[stab[i].ch]), 1);
      wait_cen(stab[i].ch, 300, e);
      check($sformatf("scn%0d_apply_edge", i), e, stab[i].exp1);
      check($sformatf("scn%0d_pend_clr", i), int'(bus.PEND[stab[i].ch]), 0);
      wait_cen(stab[i].ch, 300, e);
      check($sformatf("scn%0d_next_edge", i), e, stab[i].exp2);
    end

    // Stop ch3 with N=0, then restart it with N=1.
    do_reset();
    write_at(101, 3'b110, 16'd0);
    check("stop_pend_set", int'(bus.PEND[3]), 1);
    wait_cen(3, 200, e);
    check("stop_apply_edge", e, 192);
    check("stop_pend_clr", int'(bus.PEND[3]), 0);
    pcnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.CEN[3] || bus.CENB[3]) pcnt++;
    end
    check("stopped_pulses", pcnt, 0);
    write_at(edge_n + 1, 3'b110, 16'd1);
    e = edge_n;
    check("start_pend_set", int'(bus.PEND[3]), 1);
    tick();
    check("start_pend_clr", int'(bus.PEND[3]), 0);
    wait_cen(3, 200, pcnt);
    check("start_first_gap", pcnt - (e + 1), 96);

    // Pause for 100 edges mid-period.
    do_reset();
    run_to(29);
    bus.PAUSE = 1'b1;
    pcnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.CEN != 4'd0 || bus.CENB != 4'd0) pcnt++;
    end
    bus.PAUSE = 1'b0;
    check("pause_pulses", pcnt, 0);
    wait_cen(0, 100, e);
    check("pause_resume_edge", e, 148);

    // Write to ch1 on the very edge its pending rate applies.
    do_reset();
    write_at(10, 3'b010, 16'd2);
    write_at(48, 3'b011, 16'd96);
    check("wapply_cen", int'(bus.CEN[1]), 1);
    check("wapply_pend_kept", int'(bus.PEND[1]), 1);
    wait_cen(1, 100, e);
    check("wapply_old_shadow_edge", e, 72);
    check("wapply_pend_clr", int'(bus.PEND[1]), 0);
    wait_cen(1, 100, e);
    check("wapply_new_rate_edge", e, 120);

    // Async reset while CEN[0] and PEND[1] are high.
    do_reset();
    write_at(5, 3'b011, 16'd12);
    run_to(24);
    check("arst_pre_cen0", int'(bus.CEN[0]), 1);
    check("arst_pre_pend1", int'(bus.PEND[1]), 1);
    #2;
    RESET96_N = 1'b0;
    model_reset();
    #1;
    check("arst_outputs", int'({bus.PEND, bus.CENB, bus.CEN}), 0);
    @(negedge CLK96);
    RESET96_N = 1'b1;
    edge_n = 0;
    wait_cen(1, 100, e);
    check("arst_default_rate_ch1", e, 48);

    // Random register traffic and pause toggling against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      bus.WR   = ($urandom_range(0, 15) == 0);
      bus.ADDR = 3'($urandom_range(0, 7));
      if (bus.ADDR[0]) bus.DIN = 16'($urandom_range(0, 40));
      else bus.DIN = {8'($urandom), 8'($urandom_range(0, 12))};
      if ($urandom_range(0, 39) == 0) bus.PAUSE = ~bus.PAUSE;
      tick();
    end
    bus.WR = 1'b0; bus.PAUSE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
